// File: rtl/rtlola_cycle_monitor_pkg.sv
// Shared types and sizing for the RTLola cycle monitor: stream width, timer period, queue depth.
// Queue entries carry the sampled input value plus the pacing bits decided at push time.
package rtlola_cycle_monitor_pkg;

   localparam int DATA_W        = 64;
   localparam int PERIOD_CYCLES = 500;
   localparam int QUEUE_DEPTH   = 4;

   typedef struct packed {
      logic in0;
      logic out0;
      logic out1;
   } pacing_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] value;
      pacing_t                  pacing;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/rtlola_event_queue.sv
// Synchronous FIFO; pushed data is readable at the head the cycle after the push edge.
// Push while full is dropped (push_ack=0); pop while empty is ignored (pop_ack=0).
module rtlola_event_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_req,
   input  logic [WIDTH-1:0] push_dat,
   output logic             push_ack,
   input  logic             pop_req,
   output logic [WIDTH-1:0] pop_dat,
   output logic             pop_ack,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full;

   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign push_ack = push_req & ~full;
   assign pop_ack  = pop_req & ~empty;
   assign pop_dat  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ack) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ack) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_ack, pop_ack})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the occupancy count gates every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/rtlola_cycle_monitor.sv
// RTLola monitor top: timer + input events feed the event queue; evaluator pops one entry per cycle.
// Event at edge E is popped in cycle E..E+1, results registered at E+1; en low freezes all state.
module rtlola_cycle_monitor
   import rtlola_cycle_monitor_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] input_0,
   input  logic                     new_input_0,
   output logic signed [DATA_W-1:0] output_0,
   output logic                     output_0_aktv,
   output logic signed [DATA_W-1:0] output_1,
   output logic                     output_1_aktv,
   output logic                     q_push,
   output logic                     q_pop,
   output logic                     q_push_valid,
   output logic                     q_pop_valid,
   output logic                     pacing_in0,
   output logic                     pacing_out0_0,
   output logic                     pacing_out1_0
);

   localparam int CNT_W = $clog2(PERIOD_CYCLES);
   localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic signed [DATA_W-1:0] ONE      = DATA_W'(1);

   logic                     run;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     tick;
   entry_t                   push_ent;
   entry_t                   pop_ent;
   logic [ENTRY_W-1:0]       pop_dat;
   logic                     push_ack, pop_ack, q_empty;
   logic signed [DATA_W-1:0] out0_q, out0_d;
   logic signed [DATA_W-1:0] out1_q, out1_d;
   logic                     aktv0_q, aktv0_d;
   logic                     aktv1_q, aktv1_d;

   assign run = rst & en;

   // Tick fires in the cycle the counter sits at its last value, so the entry lands on the wrap edge.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (en) begin
         if (cnt_q == CNT_LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      push_ent.value       = input_0;
      push_ent.pacing.in0  = new_input_0;
      push_ent.pacing.out0 = new_input_0;
      push_ent.pacing.out1 = tick;
   end

   assign q_push = run & (new_input_0 | tick);
   assign q_pop  = run & ~q_empty;

   rtlola_event_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .push_req (q_push),
      .push_dat (push_ent),
      .push_ack (push_ack),
      .pop_req  (q_pop),
      .pop_dat  (pop_dat),
      .pop_ack  (pop_ack),
      .empty    (q_empty)
   );

   assign pop_ent       = pop_dat;
   assign q_push_valid  = push_ack;
   assign q_pop_valid   = pop_ack;
   assign pacing_in0    = pop_ack & pop_ent.pacing.in0;
   assign pacing_out0_0 = pop_ack & pop_ent.pacing.out0;
   assign pacing_out1_0 = pop_ack & pop_ent.pacing.out1;

   // Both hold reads use the registered values, so a doubly-paced entry sees the previous pair.
   always_comb begin
      out0_d  = out0_q;
      out1_d  = out1_q;
      aktv0_d = 1'b0;
      aktv1_d = 1'b0;
      if (pacing_out0_0) begin
         out0_d  = pop_ent.value + out1_q;
         aktv0_d = 1'b1;
      end
      if (pacing_out1_0) begin
         out1_d  = out0_q + ONE;
         aktv1_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= '0;
         out0_q  <= '0;
         out1_q  <= '0;
         aktv0_q <= 1'b0;
         aktv1_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         aktv0_q <= aktv0_d;
         aktv1_q <= aktv1_d;
      end
   end

   assign output_0      = out0_q;
   assign output_1      = out1_q;
   assign output_0_aktv = aktv0_q;
   assign output_1_aktv = aktv1_q;

endmodule

// File: tb/tb_rtlola_cycle_monitor.sv
// Directed bench for rtlola_cycle_monitor: timer ticks, input events, hold cycle, wrap, reset, enable.
// Inputs driven and outputs sampled on the falling edge; t counts rising edges since reset release.
module tb_rtlola_cycle_monitor;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic signed [63:0] input_0;
   logic               new_input_0;
   logic signed [63:0] output_0;
   logic               output_0_aktv;
   logic signed [63:0] output_1;
   logic               output_1_aktv;
   logic               q_push, q_pop, q_push_valid, q_pop_valid;
   logic               pacing_in0, pacing_out0_0, pacing_out1_0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rtlola_cycle_monitor dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .input_0       (input_0),
      .new_input_0   (new_input_0),
      .output_0      (output_0),
      .output_0_aktv (output_0_aktv),
      .output_1      (output_1),
      .output_1_aktv (output_1_aktv),
      .q_push        (q_push),
      .q_pop         (q_pop),
      .q_push_valid  (q_push_valid),
      .q_pop_valid   (q_pop_valid),
      .pacing_in0    (pacing_in0),
      .pacing_out0_0 (pacing_out0_0),
      .pacing_out1_0 (pacing_out1_0)
   );

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0; en = 1'b1; new_input_0 = 1'b0; input_0 = '0;
      adv(2); #1;
      n_vec++; if (output_0 !== 64'd0) begin n_err++; $display("FAIL rst_out0 got %0h want 0", output_0); end
      n_vec++; if (output_1 !== 64'd0) begin n_err++; $display("FAIL rst_out1 got %0h want 0", output_1); end
      n_vec++; if ({output_0_aktv, output_1_aktv, q_push, q_pop, q_push_valid, q_pop_valid, pacing_in0, pacing_out0_0, pacing_out1_0} !== 9'b0)
         begin n_err++; $display("FAIL rst_flags got %b want 000000000", {output_0_aktv, output_1_aktv, q_push, q_pop, q_push_valid, q_pop_valid, pacing_in0, pacing_out0_0, pacing_out1_0}); end
      rst = 1'b1;
   endtask

   task automatic test_first_ticks;
      adv(499); #1;
      n_vec++; if ({q_push, q_pop, output_1_aktv} !== 3'b100) begin n_err++; $display("FAIL tick1_push got %b want 100", {q_push, q_pop, output_1_aktv}); end
      adv(1); #1;
      n_vec++; if ({q_pop, pacing_in0, pacing_out0_0, pacing_out1_0, output_1_aktv} !== 5'b10010) begin n_err++; $display("FAIL tick1_pop got %b want 10010", {q_pop, pacing_in0, pacing_out0_0, pacing_out1_0, output_1_aktv}); end
      adv(1);
      n_vec++; if (output_1 !== 64'd1) begin n_err++; $display("FAIL tick1_out1 got %0h want 1", output_1); end
      n_vec++; if ({output_0_aktv, output_1_aktv} !== 2'b01) begin n_err++; $display("FAIL tick1_aktv got %b want 01", {output_0_aktv, output_1_aktv}); end
      n_vec++; if (output_0 !== 64'd0) begin n_err++; $display("FAIL tick1_out0 got %0h want 0", output_0); end
      adv(1);
      n_vec++; if ({output_1_aktv, output_1} !== {1'b0, 64'd1}) begin n_err++; $display("FAIL tick1_pulse got %b/%0h want 0/1", output_1_aktv, output_1); end
      adv(499);
      n_vec++; if ({output_1_aktv, output_1} !== {1'b1, 64'd1}) begin n_err++; $display("FAIL tick2_out1 got %b/%0h want 1/1", output_1_aktv, output_1); end
   endtask

   task automatic test_single_input;
      adv(1); input_0 = 64'sd1; new_input_0 = 1'b1; #1;
      n_vec++; if (q_push_valid !== 1'b1) begin n_err++; $display("FAIL in1_pushv got %b want 1", q_push_valid); end
      adv(1); new_input_0 = 1'b0; #1;
      n_vec++; if ({pacing_in0, pacing_out0_0, pacing_out1_0} !== 3'b110) begin n_err++; $display("FAIL in1_pacing got %b want 110", {pacing_in0, pacing_out0_0, pacing_out1_0}); end
      adv(1);
      n_vec++; if (output_0 !== 64'd2) begin n_err++; $display("FAIL in1_out0 got %0h want 2", output_0); end
      n_vec++; if ({output_0_aktv, output_1_aktv} !== 2'b10) begin n_err++; $display("FAIL in1_aktv got %b want 10", {output_0_aktv, output_1_aktv}); end
      adv(1);
      n_vec++; if ({output_0_aktv, output_0} !== {1'b0, 64'd2}) begin n_err++; $display("FAIL in1_pulse got %b/%0h want 0/2", output_0_aktv, output_0); end
      adv(496);
      n_vec++; if ({output_1_aktv, output_1} !== {1'b1, 64'd3}) begin n_err++; $display("FAIL tick3_out1 got %b/%0h want 1/3", output_1_aktv, output_1); end
   endtask

   task automatic test_back_to_back;
      adv(1); input_0 = 64'sd2; new_input_0 = 1'b1; #1;
      n_vec++; if (q_push_valid !== 1'b1) begin n_err++; $display("FAIL b2b_pushv0 got %b want 1", q_push_valid); end
      adv(1); input_0 = 64'sd3; #1;
      n_vec++; if ({q_push_valid, q_pop_valid} !== 2'b11) begin n_err++; $display("FAIL b2b_pushv1 got %b want 11", {q_push_valid, q_pop_valid}); end
      adv(1);
      n_vec++; if ({output_0_aktv, output_0} !== {1'b1, 64'd5}) begin n_err++; $display("FAIL b2b_out0_5 got %b/%0h want 1/5", output_0_aktv, output_0); end
      input_0 = 64'sd4; #1;
      n_vec++; if ({q_push_valid, q_pop_valid} !== 2'b11) begin n_err++; $display("FAIL b2b_pushv2 got %b want 11", {q_push_valid, q_pop_valid}); end
      adv(1); new_input_0 = 1'b0;
      n_vec++; if ({output_0_aktv, output_0} !== {1'b1, 64'd6}) begin n_err++; $display("FAIL b2b_out0_6 got %b/%0h want 1/6", output_0_aktv, output_0); end
      adv(1);
      n_vec++; if ({output_0_aktv, output_0} !== {1'b1, 64'd7}) begin n_err++; $display("FAIL b2b_out0_7 got %b/%0h want 1/7", output_0_aktv, output_0); end
      n_vec++; if ({output_1_aktv, output_1} !== {1'b0, 64'd3}) begin n_err++; $display("FAIL b2b_out1 got %b/%0h want 0/3", output_1_aktv, output_1); end
      adv(1);
      n_vec++; if ({output_0_aktv, q_pop} !== 2'b00) begin n_err++; $display("FAIL b2b_drain got %b want 00", {output_0_aktv, q_pop}); end
   endtask

   task automatic test_simultaneous;
      adv(492); #1;
      n_vec++; if (q_push !== 1'b1) begin n_err++; $display("FAIL sim_tick got %b want 1", q_push); end
      input_0 = 64'sd10; new_input_0 = 1'b1; #1;
      n_vec++; if ({q_push, q_push_valid} !== 2'b11) begin n_err++; $display("FAIL sim_push got %b want 11", {q_push, q_push_valid}); end
      adv(1); new_input_0 = 1'b0; #1;
      n_vec++; if ({pacing_in0, pacing_out0_0, pacing_out1_0} !== 3'b111) begin n_err++; $display("FAIL sim_pacing got %b want 111", {pacing_in0, pacing_out0_0, pacing_out1_0}); end
      adv(1);
      n_vec++; if (output_0 !== 64'd13) begin n_err++; $display("FAIL sim_out0 got %0d want 13", output_0); end
      n_vec++; if (output_1 !== 64'd8) begin n_err++; $display("FAIL sim_out1 got %0d want 8", output_1); end
      n_vec++; if ({output_0_aktv, output_1_aktv, q_pop} !== 3'b110) begin n_err++; $display("FAIL sim_aktv got %b want 110", {output_0_aktv, output_1_aktv, q_pop}); end
   endtask

   task automatic test_reset_mid_run;
      adv(1); input_0 = 64'sd5; new_input_0 = 1'b1;
      adv(1);
      n_vec++; if (q_pop !== 1'b1) begin n_err++; $display("FAIL mid_queued got %b want 1", q_pop); end
      rst = 1'b0; #1;
      n_vec++; if ({q_push, q_pop, q_push_valid, q_pop_valid, pacing_in0, pacing_out0_0, pacing_out1_0} !== 7'b0)
         begin n_err++; $display("FAIL mid_gated got %b want 0000000", {q_push, q_pop, q_push_valid, q_pop_valid, pacing_in0, pacing_out0_0, pacing_out1_0}); end
      adv(1); new_input_0 = 1'b0;
      n_vec++; if ({output_0, output_1, output_0_aktv, output_1_aktv} !== 130'b0) begin n_err++; $display("FAIL mid_clear got %0h/%0h/%b%b want 0/0/00", output_0, output_1, output_0_aktv, output_1_aktv); end
      adv(1); rst = 1'b1;
      adv(1);
      n_vec++; if ({q_pop, output_0_aktv} !== 2'b00) begin n_err++; $display("FAIL mid_discard got %b want 00", {q_pop, output_0_aktv}); end
      adv(1);
      n_vec++; if ({output_0_aktv, output_0} !== {1'b0, 64'd0}) begin n_err++; $display("FAIL mid_noaktv got %b/%0h want 0/0", output_0_aktv, output_0); end
      adv(497); #1;
      n_vec++; if ({q_push, q_pop} !== 2'b10) begin n_err++; $display("FAIL mid_tick_push got %b want 10", {q_push, q_pop}); end
      adv(1); #1;
      n_vec++; if ({q_pop, pacing_out1_0} !== 2'b11) begin n_err++; $display("FAIL mid_tick_pop got %b want 11", {q_pop, pacing_out1_0}); end
      adv(1);
      n_vec++; if ({output_1_aktv, output_1} !== {1'b1, 64'd1}) begin n_err++; $display("FAIL mid_tick_out1 got %b/%0h want 1/1", output_1_aktv, output_1); end
   endtask

   task automatic test_overflow;
      adv(1); input_0 = 64'sh7FFF_FFFF_FFFF_FFFF; new_input_0 = 1'b1;
      adv(1); new_input_0 = 1'b0;
      adv(1);
      n_vec++; if (output_0 !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL ovf_out0 got %0h want 8000000000000000", output_0); end
      n_vec++; if (output_0_aktv !== 1'b1) begin n_err++; $display("FAIL ovf_aktv got %b want 1", output_0_aktv); end
   endtask

   task automatic test_enable;
      input_0 = 64'sd7; new_input_0 = 1'b1;
      adv(1); en = 1'b0; input_0 = 64'sd99; #1;
      n_vec++; if ({q_push, q_pop, q_push_valid, pacing_in0} !== 4'b0) begin n_err++; $display("FAIL en_gated got %b want 0000", {q_push, q_pop, q_push_valid, pacing_in0}); end
      adv(45);
      n_vec++; if (output_0 !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL en_hold_out0 got %0h want 8000000000000000", output_0); end
      n_vec++; if ({output_0_aktv, output_1_aktv, q_pop} !== 3'b000) begin n_err++; $display("FAIL en_idle got %b want 000", {output_0_aktv, output_1_aktv, q_pop}); end
      adv(55); en = 1'b1; new_input_0 = 1'b0; #1;
      n_vec++; if ({q_pop, pacing_in0} !== 2'b11) begin n_err++; $display("FAIL en_resume_pop got %b want 11", {q_pop, pacing_in0}); end
      adv(1);
      n_vec++; if ({output_0_aktv, output_0} !== {1'b1, 64'd8}) begin n_err++; $display("FAIL en_out0 got %b/%0h want 1/8", output_0_aktv, output_0); end
      adv(393); #1;
      n_vec++; if ({q_push, output_1} !== {1'b0, 64'd1}) begin n_err++; $display("FAIL en_no_early_tick got %b/%0h want 0/1", q_push, output_1); end
      adv(100); #1;
      n_vec++; if (q_push !== 1'b1) begin n_err++; $display("FAIL en_delayed_tick got %b want 1", q_push); end
      adv(1); #1;
      n_vec++; if (pacing_out1_0 !== 1'b1) begin n_err++; $display("FAIL en_tick_pop got %b want 1", pacing_out1_0); end
      adv(1);
      n_vec++; if (output_1 !== 64'd9) begin n_err++; $display("FAIL en_tick_out1 got %0d want 9", output_1); end
      n_vec++; if ({output_0_aktv, output_1_aktv} !== 2'b01) begin n_err++; $display("FAIL en_tick_aktv got %b want 01", {output_0_aktv, output_1_aktv}); end
   endtask

   initial begin
      test_reset();
      test_first_ticks();
      test_single_input();
      test_back_to_back();
      test_simultaneous();
      test_reset_mid_run();
      test_overflow();
      test_enable();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion before it");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rtlola_cycle_monitor.md
Name: rtlola_cycle_monitor

Overview:
Hardware runtime monitor for one signed 64-bit input stream and two output streams that form a non-offset cycle:
- output_0 is event-based: it is paced by input_0 and reads output_1 via hold.
- output_1 is periodic: it is paced by an internal timer and reads output_0 via hold.

A high-level controller timestamps input events and timer ticks and pushes them into an event queue. A low-level evaluator pops each entry and computes the streams. The block is the top level of the generated monitor.

Parameters:
- DATA_W, 64, width of input and output stream values (signed).
- PERIOD_CYCLES, 500, clock cycles between output_1 evaluations (1 ms at a 500 kHz clock).
- QUEUE_DEPTH, 4, number of event-queue entries.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  global enable; when low, all state is frozen.
- input_0  in  DATA_W  signed value of input stream 0.
- new_input_0  in  1  input_0 carries a new event this cycle.
- output_0  out  DATA_W  value of stream output_0.
- output_0_aktv  out  1  output_0 evaluated this cycle.
- output_1  out  DATA_W  value of stream output_1.
- output_1_aktv  out  1  output_1 evaluated this cycle.
- q_push  out  1  push requested (event or tick present, en high).
- q_pop  out  1  pop requested (queue non-empty, en high).
- q_push_valid  out  1  push accepted (q_push and not full).
- q_pop_valid  out  1  pop delivered an entry.
- pacing_in0  out  1  popped entry carries an input_0 event.
- pacing_out0_0  out  1  popped entry schedules output_0.
- pacing_out1_0  out  1  popped entry schedules output_1.

Behaviour:
Stream semantics:
- output_0 = input_0 + hold(output_1, default 0).
- output_1 = hold(output_0, default 0) + 1.
- Both hold reads return the value committed before the current entry. Consequently, when both streams are paced in one entry, each uses the other's previous value.
- Arithmetic is two's-complement DATA_W, wrapping, with no saturation.

Timer:
- Cycle counter 0..PERIOD_CYCLES-1.
- A tick is generated when the counter wraps. The first tick occurs PERIOD_CYCLES enabled cycles after reset release.
- The counter holds while en is low.

Push:
- In any enabled cycle with new_input_0 or a tick, one entry {input_0, pacing bits} is pushed.
- pacing_in0 and pacing_out0_0 are set by new_input_0; pacing_out1_0 is set by the tick.
- A simultaneous input and tick produce a single entry with all three bits set.

Queue:
- FIFO of QUEUE_DEPTH entries. Push and pop in the same cycle are both allowed.
- Push while full: the entry is dropped, q_push_valid=0, and queue contents are unchanged.
- Pop while empty: q_pop=0, q_pop_valid=0.

Latency:
- An event sampled at edge E is stored at E.
- It is popped in the cycle after E; pacing_* are valid that cycle.
- Outputs and aktv are registered at edge E+1 and are visible for exactly one cycle.
- An aktv flag is high only for the stream paced by that entry. The non-paced output keeps its last value.

Reset (rst=0 at an edge):
- Queue emptied; timer set to 0.
- Held values set to 0; output_0 and output_1 set to 0.
- All aktv, q_* and pacing_* signals read 0.
- Reset mid-operation discards all queued entries.

Enable:
- en low: no push, no pop, no timer advance, outputs hold their values, aktv=0.

Decomposition:
- Shared package: DATA_W, PERIOD_CYCLES, QUEUE_DEPTH, a pacing struct {in0, out0, out1}, and a queue entry struct {value, pacing}.
- One sub-module, rtlola_event_queue: a parameterised synchronous FIFO with full/empty flags and push/pop acknowledges.
- Timer, push logic and evaluator stay in the top level.

Test Plan:
- Reset, then idle 1000 us: the first tick gives output_1=1 with output_1_aktv=1 and output_0_aktv=0. The next tick gives output_1=1 again.
- After the first tick, input_0=1: output_0=2 two edges later, output_0_aktv=1 for one cycle. The next tick gives output_1=3.
- Inputs 2, 3, 4 on consecutive cycles with no tick: three pops on consecutive cycles. With output_1=3 held: output_0=5, 6, 7, and q_push_valid=1 each cycle.
- An input of 10 landing on the tick cycle, with prior output_0=7 and output_1=3: one entry with all pacing bits set. Results are output_0=13 and output_1=8, both aktv high in the same cycle.
- Input 0x7FFF_FFFF_FFFF_FFFF with held output_1=1: output_0 wraps to 0x8000_0000_0000_0000.
- Assert rst low mid-run with entries queued: outputs read 0, no aktv follows, and the timer restarts (first tick PERIOD_CYCLES cycles after release). en held low for 100 cycles delays the tick by 100 cycles.
